// File: rtl/des_pkg.sv
// Shared types, constants and key-schedule helper for the DES round sequencer.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;
  localparam int unsigned RC_W       = 4;
  localparam int unsigned MAP_W      = 16;

  // Bit r-1 set: encrypt round r rotates C/D by one bit, otherwise by two.
  localparam logic [MAP_W-1:0] DES_SHIFT1_MAP = 16'h8103;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } des_state_e;

  // Rotate-by-two select for round counter rc. Decrypt walks the encrypt
  // schedule backwards, so decrypt round rc undoes encrypt round 16-rc+1.
  function automatic logic shift_two(input logic [RC_W-1:0]  rc,
                                     input logic             decrypt,
                                     input logic [MAP_W-1:0] map = DES_SHIFT1_MAP);
    logic [RC_W-1:0] idx;
    idx = decrypt ? RC_W'(5'd16 - {1'b0, rc}) : rc;
    return ~map[idx];
  endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Block-level handshakes between the round sequencer and its producer/consumer.
interface des_round_ctrl_if;
  import des_pkg::*;

  logic start_valid;
  logic start_ready;
  logic decrypt;
  logic out_valid;
  logic out_ready;

  modport master (
    output start_valid,
    output decrypt,
    output out_ready,
    input  start_ready,
    input  out_valid
  );

  modport slave (
    input  start_valid,
    input  decrypt,
    input  out_ready,
    output start_ready,
    output out_valid
  );

endinterface

// File: rtl/des_key_shift_sel.sv
// Maps round counter and mode onto the C/D rotate enable and amount.
module des_key_shift_sel
  import des_pkg::*;
#(
  parameter logic [MAP_W-1:0] SHIFT1_MAP = DES_SHIFT1_MAP
) (
  input  logic [RC_W-1:0] rc_i,
  input  logic            decrypt_i,
  output logic            key_rot_en_o,
  output logic            key_rot_two_o
);

  // Decrypt round 0 uses the unrotated C0/D0, which equals C16/D16.
  always_comb begin
    key_rot_en_o  = 1'b1;
    key_rot_two_o = 1'b0;
    if (decrypt_i && (rc_i == '0)) begin
      key_rot_en_o = 1'b0;
    end else begin
      key_rot_two_o = shift_two(rc_i, decrypt_i, SHIFT1_MAP);
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: one round per clock, 16 rounds per block.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int unsigned      NUM_ROUNDS = DES_ROUNDS,
  parameter logic [MAP_W-1:0] SHIFT1_MAP = DES_SHIFT1_MAP
) (
  input  logic              clk,
  input  logic              rst_n,
  des_round_ctrl_if.slave   hs,
  output logic              ld_data_o,
  output logic              ld_key_o,
  output logic              rnd_en_o,
  output logic              key_rot_en_o,
  output logic              key_rot_two_o,
  output logic              key_dir_o,
  output logic [RC_W-1:0]   round_o,
  output logic              last_round_o,
  output logic              busy_o
);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS - 1);

  des_state_e      state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            mode_q, mode_d;
  logic            start_hs;
  logic            rot_en_d, rot_two_d;

  logic            start_ready_q;
  logic            out_valid_q;
  logic            rnd_en_q;
  logic            key_rot_en_q;
  logic            key_rot_two_q;
  logic            key_dir_q;
  logic [RC_W-1:0] round_q;
  logic            last_round_q;
  logic            busy_q;

  // Load strobes are the only paths straight from an input.
  assign start_hs  = (state_q == ST_IDLE) && hs.start_valid;
  assign ld_data_o = start_hs;
  assign ld_key_o  = start_hs;

  // Next state, round counter and captured mode.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (hs.start_valid) begin
          state_d = ST_ROUND;
          rc_d    = '0;
          mode_d  = hs.decrypt;
        end
      end
      ST_ROUND: begin
        if (rc_q == RC_LAST) begin
          state_d = ST_DONE;
          rc_d    = '0;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      ST_DONE: begin
        if (hs.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rc_d    = '0;
      end
    endcase
  end

  // Rotation select for the round about to be entered.
  des_key_shift_sel #(
    .SHIFT1_MAP (SHIFT1_MAP)
  ) u_shift_sel (
    .rc_i          (rc_d),
    .decrypt_i     (mode_d),
    .key_rot_en_o  (rot_en_d),
    .key_rot_two_o (rot_two_d)
  );

  // State and control outputs, registered from next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rc_q          <= '0;
      mode_q        <= 1'b0;
      start_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
      rnd_en_q      <= 1'b0;
      key_rot_en_q  <= 1'b0;
      key_rot_two_q <= 1'b0;
      key_dir_q     <= 1'b0;
      round_q       <= '0;
      last_round_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rc_q          <= rc_d;
      mode_q        <= mode_d;
      start_ready_q <= (state_d == ST_IDLE);
      out_valid_q   <= (state_d == ST_DONE);
      rnd_en_q      <= (state_d == ST_ROUND);
      key_rot_en_q  <= (state_d == ST_ROUND) && rot_en_d;
      key_rot_two_q <= (state_d == ST_ROUND) && rot_en_d && rot_two_d;
      key_dir_q     <= (state_d == ST_ROUND) && mode_d;
      round_q       <= (state_d == ST_ROUND) ? rc_d : '0;
      last_round_q  <= (state_d == ST_ROUND) && (rc_d == RC_LAST);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign hs.start_ready = start_ready_q;
  assign hs.out_valid   = out_valid_q;
  assign rnd_en_o       = rnd_en_q;
  assign key_rot_en_o   = key_rot_en_q;
  assign key_rot_two_o  = key_rot_two_q;
  assign key_dir_o      = key_dir_q;
  assign round_o        = round_q;
  assign last_round_o   = last_round_q;
  assign busy_o         = busy_q;

  // Only the standard 16-round schedule is implemented.
  a_num_rounds: assert property (@(posedge clk) NUM_ROUNDS == DES_ROUNDS);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench: controller plus a behavioural DES datapath driven by it.
module tb_des_round_ctrl;

  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  localparam int ENC_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                              12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                              24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SBOX_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic clk = 1'b0;
  logic rst_n;
  logic ld_data, ld_key, rnd_en, key_rot_en, key_rot_two, key_dir, last_round, busy;
  logic [3:0] round;

  logic [63:0] blk_in, key_in, dp_out;
  logic [31:0] dp_l, dp_r;
  logic [27:0] dp_c, dp_d;

  logic [63:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  des_round_ctrl_if bus ();

  des_round_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs            (bus),
    .ld_data_o     (ld_data),
    .ld_key_o      (ld_key),
    .rnd_en_o      (rnd_en),
    .key_rot_en_o  (key_rot_en),
    .key_rot_two_o (key_rot_two),
    .key_dir_o     (key_dir),
    .round_o       (round),
    .last_round_o  (last_round),
    .busy_o        (busy)
  );

  function automatic logic [63:0] ip_fn(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_fn(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_fn(input logic [63:0] k);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_fn(input logic [55:0] cd);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rot_fn(input logic [27:0] v, input logic two, input logic right);
    case ({right, two})
      2'b00:   return {v[26:0], v[27]};
      2'b01:   return {v[25:0], v[27:26]};
      2'b10:   return {v[0], v[27:1]};
      default: return {v[1:0], v[27:2]};
    endcase
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    logic [5:0]  b;
    int          idx;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = x[47-6*i -: 6];
      idx = 64*i + 16*int'({b[5], b[0]}) + int'(b[4:1]);
      s[31-4*i -: 4] = 4'(SBOX_T[idx]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  // Behavioural round datapath obeying the controller's strobes.
  always @(posedge clk) begin : datapath
    logic [27:0] cn, dn;
    logic [31:0] fo;
    if (ld_data) begin
      {dp_l, dp_r} <= ip_fn(blk_in);
      {dp_c, dp_d} <= pc1_fn(key_in);
    end else if (rnd_en) begin
      cn = key_rot_en ? rot_fn(dp_c, key_rot_two, key_dir) : dp_c;
      dn = key_rot_en ? rot_fn(dp_d, key_rot_two, key_dir) : dp_d;
      fo = f_fn(dp_r, pc2_fn({cn, dn}));
      if (last_round) begin
        dp_l <= dp_l ^ fo;
      end else begin
        dp_l <= dp_r;
        dp_r <= dp_l ^ fo;
      end
      dp_c <= cn;
      dp_d <= dn;
    end
  end

  assign dp_out = fp_fn({dp_l, dp_r});

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_pop(input string tag);
    if (exp_q.size() == 0) check_eq({tag, "_underflow"}, 64'(exp_q.size()), 64'd1);
    else check_eq(tag, dp_out, exp_q.pop_front());
  endtask

  // Wait for start_ready, then present one block in the current cycle (cycle 0).
  task automatic start_block(input logic [63:0] blk, input logic dec, input logic [63:0] exp);
    int waited = 0;
    @(negedge clk); #1;
    while (!bus.start_ready && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("start_ready_wait", 64'(bus.start_ready), 64'd1);
    blk_in          = blk;
    key_in          = KEY;
    bus.decrypt     = dec;
    bus.start_valid = 1'b1;
    #1;
    check_eq("ld_data", 64'(ld_data), 64'd1);
    check_eq("ld_key", 64'(ld_key), 64'd1);
    exp_q.push_back(exp);
  endtask

  // Cycles 1..16: check per-round controls; may stop early after round stop_at.
  task automatic run_rounds(input logic dec, input int stop_at, output int rot_total);
    logic exp_en;
    int   amt;
    rot_total = 0;
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      if (r == 0) begin
        bus.start_valid = 1'b0;
        bus.decrypt     = 1'($urandom);
      end
      #1;
      check_eq("rnd_en", 64'(rnd_en), 64'd1);
      check_eq("round", 64'(round), 64'(r));
      check_eq("last_round", 64'(last_round), 64'(r == 15));
      check_eq("key_dir", 64'(key_dir), 64'(dec));
      check_eq("busy_round", 64'(busy), 64'd1);
      check_eq("start_ready_round", 64'(bus.start_ready), 64'd0);
      check_eq("out_valid_round", 64'(bus.out_valid), 64'd0);
      check_eq("ld_round", 64'(ld_data), 64'd0);
      exp_en = !(dec && r == 0);
      amt    = dec ? ((r == 0) ? 0 : ENC_SHIFT[16-r]) : ENC_SHIFT[r];
      check_eq("key_rot_en", 64'(key_rot_en), 64'(exp_en));
      if (exp_en) check_eq("key_rot_two", 64'(key_rot_two), 64'(amt == 2));
      if (key_rot_en) rot_total += key_rot_two ? 2 : 1;
      if (r == stop_at) return;
    end
  endtask

  // Cycle 17 onward: DONE held for `hold` cycles with ignored start pulses.
  task automatic finish_block(input int hold);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      bus.out_ready   = (h == hold);
      bus.start_valid = (h < hold) && ((h % 2) == 0);
      #1;
      check_eq("out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("rnd_en_done", 64'(rnd_en), 64'd0);
      check_eq("key_rot_en_done", 64'(key_rot_en), 64'd0);
      check_eq("start_ready_done", 64'(bus.start_ready), 64'd0);
      check_eq("ld_done", 64'(ld_data | ld_key), 64'd0);
      check_eq("busy_done", 64'(busy), 64'd1);
      if (bus.out_valid && bus.out_ready) sb_pop("result");
    end
    @(negedge clk);
    bus.out_ready   = 1'b0;
    bus.start_valid = 1'b0;
    #1;
    check_eq("idle_start_ready", 64'(bus.start_ready), 64'd1);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   tot;
    int   last_ld;
    int   n_ld;
    logic cur_mode;

    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.decrypt     = 1'b0;
    bus.out_ready   = 1'b0;
    blk_in          = '0;
    key_in          = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_start_ready", 64'(bus.start_ready), 64'd1);
    check_eq("rst_outs", 64'({ld_data, ld_key, rnd_en, key_rot_en, key_rot_two, key_dir,
                              last_round, bus.out_valid, busy}), 64'd0);
    check_eq("rst_round", 64'(round), 64'd0);
    rst_n = 1'b1;

    // Encrypt known answer.
    start_block(PT, 1'b0, CT);
    run_rounds(1'b0, 16, tot);
    check_eq("enc_rot_total", 64'(tot), 64'd28);
    finish_block(0);

    // Decrypt known answer.
    start_block(CT, 1'b1, PT);
    run_rounds(1'b1, 16, tot);
    check_eq("dec_rot_total", 64'(tot), 64'd27);
    finish_block(0);

    // Output backpressure.
    start_block(PT, 1'b0, CT);
    run_rounds(1'b0, 16, tot);
    finish_block(5);

    // Reset in the middle of round 7.
    start_block(PT, 1'b0, CT);
    run_rounds(1'b0, 7, tot);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_rnd_en", 64'(rnd_en), 64'd0);
    check_eq("midrst_start_ready", 64'(bus.start_ready), 64'd1);
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    void'(exp_q.pop_back());
    rst_n = 1'b1;
    start_block(CT, 1'b1, PT);
    run_rounds(1'b1, 16, tot);
    finish_block(0);

    // Back-to-back with alternating mode.
    @(posedge clk); #1;
    bus.start_valid = 1'b1;
    bus.out_ready   = 1'b1;
    bus.decrypt     = 1'b0;
    blk_in          = PT;
    key_in          = KEY;
    last_ld         = -1;
    n_ld            = 0;
    cur_mode        = 1'b0;
    for (int c = 0; c < 4 * 18; c++) begin
      @(negedge clk); #1;
      if (ld_data) begin
        if (last_ld >= 0) check_eq("b2b_period", 64'(c - last_ld), 64'd18);
        last_ld  = c;
        n_ld++;
        cur_mode = bus.decrypt;
        exp_q.push_back(bus.decrypt ? PT : CT);
      end
      if (rnd_en) begin
        check_eq("b2b_key_dir", 64'(key_dir), 64'(cur_mode));
        if (round == 4'd0) check_eq("b2b_rot_en_r0", 64'(key_rot_en), 64'(!cur_mode));
      end
      if (bus.out_valid) sb_pop("b2b_result");
      @(posedge clk); #1;
      if (ld_data || (last_ld == c)) begin
        bus.decrypt = ~bus.decrypt;
        blk_in      = bus.decrypt ? CT : PT;
      end
    end
    bus.start_valid = 1'b0;
    bus.out_ready   = 1'b0;
    check_eq("b2b_blocks", 64'(n_ld), 64'd4);
    check_eq("sb_left", 64'(exp_q.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Iterative DES round sequencer. Drives one shared round datapath: L/R registers, E-expansion, the eight S-box lookups (S1..S8) and P-permutation, plus the C/D key-schedule registers.
- One round per clock; 16 rounds per block.
- Produces load, enable and key-rotate controls, tracks encrypt/decrypt mode and handles the block-level valid/ready handshakes.
- Contains no datapath storage itself.

Parameters:
- NUM_ROUNDS, 16, rounds per block. Only 16 is supported; the parameter exists for assertions.
- SHIFT1_MAP, 16'h8103, bit r-1 set means encrypt round r rotates left by 1; a clear bit means rotate by 2. The default selects rounds 1, 2, 9 and 16.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; one clock, reset synchronous, active-low
- start_valid  in  1  new block and key are presented to the datapath
- start_ready  out  1  controller can accept a block
- decrypt  in  1  mode for the block; sampled on start handshake
- ld_data  out  1  datapath loads IP(block) into L/R this edge
- ld_key  out  1  datapath loads PC1(key) into C/D this edge
- rnd_en  out  1  L/R register update enable (one round)
- key_rot_en  out  1  C/D rotate enable this cycle
- key_rot_two  out  1  rotate amount: 0 means 1 bit, 1 means 2 bits
- key_dir  out  1  rotate direction: 0 is left (encrypt), 1 is right (decrypt)
- round  out  4  current round minus 1 (0..15); 0 outside ROUND
- last_round  out  1  round 16: datapath suppresses the L/R swap
- out_valid  out  1  result in L/R is final (pre-FP)
- out_ready  in  1  consumer accepts result
- busy  out  1  state is not IDLE

Behaviour:
- States: IDLE, ROUND, DONE, held in a 2-bit state register. A 4-bit round counter rc holds 0..15. A mode register holds decrypt.
- Reset: rst_n low at a clock edge forces IDLE, rc=0, mode=0, regardless of the current state. This includes mid-ROUND and DONE; there is no partial output.
- Output values in and after reset:
  - start_ready=1.
  - All other outputs 0.
- IDLE:
  - start_ready=1.
  - When start_valid is high, ld_data=1 and ld_key=1 combinationally in the same cycle. Mode is captured, rc is set to 0, and the next state is ROUND.
  - When start_valid is low, nothing changes.
- ROUND:
  - start_ready=0.
  - rnd_en=1 every cycle.
  - round=rc.
  - last_round=(rc==15).
  - key_dir=mode.
- Key rotation, encrypt:
  - key_rot_en=1 every round.
  - key_rot_two=~SHIFT1_MAP[rc].
- Key rotation, decrypt:
  - rc==0: key_rot_en=0. The unrotated C0/D0 gives K16.
  - rc>=1: key_rot_en=1 and key_rot_two=~SHIFT1_MAP[16-rc].
  - This gives right-rotate amounts 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rc=1..15, a total of 27.
- Rotation timing: the datapath rotates C/D combinationally, forms the subkey from the rotated value and registers the rotated value on the same edge.
- rc increments each ROUND cycle. At rc==15 the next state is DONE and rc returns to 0.
- DONE:
  - out_valid=1 and is held stable until out_ready.
  - rnd_en, key_rot_en and ld_* are 0.
  - Datapath registers must not change.
  - When out_ready is high, the next state is IDLE.
  - start_ready=0 in DONE, so there is no overlap and back-to-back needs one IDLE cycle.
- Latency: start handshake in cycle 0, rounds in cycles 1..16, out_valid first high in cycle 17.
- Throughput: 18 cycles per block with out_ready tied high.
- start_valid asserted outside IDLE is ignored and does not need to be held. decrypt is a don't-care outside the handshake cycle.
- busy=1 in ROUND and DONE.
- All outputs are decoded from registered state, rc and mode. The only combinational input-to-output paths are ld_data and ld_key, driven from start_valid.

Decomposition:
- des_pkg holds:
  - the state enum (IDLE/ROUND/DONE);
  - DES_ROUNDS=16;
  - DES_SHIFT1_MAP=16'h8103;
  - a function shift_two(rc, decrypt).
- One natural sub-module: des_key_shift_sel, a purely combinational rc/mode to {key_rot_en, key_rot_two} selector. It is instantiated once.
- The FSM and counter stay in des_round_ctrl.

Test Plan:
1. Reset then encrypt:
   - Stimulus: release rst_n, pulse start_valid with decrypt=0.
   - Required: ld_data=ld_key=1 in cycle 0; rnd_en high for exactly 16 cycles with round 0..15; key_rot_two=0 at rounds 0,1,8,15 and 1 elsewhere; out_valid rises in cycle 17.
2. Decrypt schedule:
   - Stimulus: start with decrypt=1.
   - Required: key_rot_en=0 at round 0; key_dir=1; right-rotate amounts total 27; last_round high only at round 15.
3. Output backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles after DONE.
   - Required: out_valid stays 1; rnd_en=0; start_ready=0; start_valid pulses are ignored. After out_ready=1, IDLE follows with start_ready=1.
4. Reset mid-operation:
   - Stimulus: assert rst_n=0 at round 7.
   - Required: next edge gives busy=0, rnd_en=0, start_ready=1, out_valid never asserted. A new block then completes normally in 17 cycles.
5. Back-to-back:
   - Stimulus: start_valid and out_ready held high with alternating decrypt.
   - Required: ld_data every 18 cycles; mode is captured per block; key_dir is correct per block.
6. End-to-end known answer:
   - Stimulus: with the full datapath, plaintext 0123456789ABCDEF, key 133457799BBCDFF1.
   - Required: ciphertext 85E813540F0AB405; decrypting it returns the plaintext.
